ssb_sync_controller: RTL and testbench
======================================

Name: ssb_sync_controller

Overview:
- Sequences the SSB acquisition/tracking chain: gates the PSS detector search, issues SSB start to FFT demod, collects the SSS result and declares cell lock.
- Once locked, runs a flywheel timer over the SSB period and opens a narrow PSS window around the expected next SSB.
- Drops lock after repeated misses or an inconsistent N_id.
- Sits between PSS_detector / SSS_detector outputs and FFT_demod start, in the decimated sample domain.

Parameters:
- SSB_PERIOD, 38400, SSB period in decimated samples (20 ms at 1.92 Msps).
- WINDOW_HALF, 64, half-width of the tracking window in samples.
- SSS_TIMEOUT, 2048, samples to wait for the SSS result after PSS.
- MAX_MISSES, 4, consecutive missed windows before lock is lost.
- localparam CNT_W, $clog2(SSB_PERIOD + WINDOW_HALF + 1).

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- sample_valid_i  in  1  decimated sample strobe (CIC tvalid); all counters advance only on it
- N_id_2_valid_i  in  1  PSS peak pulse
- N_id_2_i  in  2  detected N_id_2
- N_id_valid_i  in  1  SSS result pulse
- N_id_i  in  10  detected N_id (0..1007)
- pss_search_en_o  out  1  enables PSS peak acceptance
- ssb_start_o  out  1  one-cycle SSB start to FFT demod
- N_id_o  out  10  locked cell id
- locked_o  out  1  cell locked
- state_o  out  2  current FSM state
- timing_err_o  out  CNT_W+1 signed  hit position minus SSB_PERIOD
- timing_err_valid_o  out  1  one-cycle strobe with timing_err_o
- miss_cnt_o  out  $clog2(MAX_MISSES+1)  consecutive misses

Behaviour:
- Reset (async assert, sync-safe deassert): state SEARCH, all outputs 0 except pss_search_en_o=1; counters 0; N_id_o=0.
- States: SEARCH=0, WAIT_SSS=1, LOCKED=2, TRACK=3.
- pss_search_en_o = 1 in SEARCH and TRACK, 0 otherwise. Peaks are ignored when it is 0.
- SEARCH: on N_id_2_valid_i, latch N_id_2, clear cnt, assert ssb_start_o for one cycle on the next edge (latency 1), go to WAIT_SSS.
- WAIT_SSS: cnt increments per sample_valid_i.
  - On N_id_valid_i, if N_id_i % 3 == latched N_id_2 (N_id_i <= 1007): latch N_id_o, set locked_o=1, clear miss_cnt, go to LOCKED.
  - On mismatch, or N_id_i > 1007: go to SEARCH.
  - When cnt reaches SSS_TIMEOUT without a result: go to SEARCH.
  - N_id_valid_i on the same cycle as the timeout counts as a result (result wins).
- LOCKED: cnt increments per sample; at cnt == SSB_PERIOD-WINDOW_HALF go to TRACK.
- TRACK: cnt continues.
  - Hit: N_id_2_valid_i with N_id_2_i == latched N_id_2 while cnt <= SSB_PERIOD+WINDOW_HALF. On a hit:
    - timing_err_o = cnt - SSB_PERIOD, pulse timing_err_valid_o;
    - cnt := 0 (the next sample then counts from 1);
    - pulse ssb_start_o; miss_cnt := 0; go to LOCKED.
  - A non-matching N_id_2 is ignored.
  - Miss: cnt reaches SSB_PERIOD+WINDOW_HALF with no hit.
    - miss_cnt++; cnt := WINDOW_HALF (flywheel realignment to the nominal SSB time); pulse ssb_start_o (blind demod).
    - If miss_cnt reaches MAX_MISSES: clear locked_o and miss_cnt, go to SEARCH. No ssb_start_o is issued in that case.
    - Otherwise go to LOCKED.
  - A hit on the same cycle the window closes counts as a hit.
- Only one ssb_start_o per SSB; the pulse never lasts longer than 1 cycle.
- N_id_2_valid_i and sample_valid_i may coincide. The peak is evaluated with the cnt value before that cycle's increment.
- Reset asserted mid-operation returns to the reset state immediately. locked_o drops asynchronously.
- N_id_o holds its last value after lock loss until the next successful SSS.

Decomposition:
- Package ssb_sync_pkg holds:
  - typedef enum logic [1:0] state_t {SEARCH, WAIT_SSS, LOCKED, TRACK};
  - N_ID_MAX=1007, N_ID_W=10.
- One sub-module is natural: ssb_window_timer, containing the cnt register, the window-open/close compares and the timing-error subtract. The FSM stays in the top module.

Test Plan:
Bench params: SSB_PERIOD=1000, WINDOW_HALF=8, SSS_TIMEOUT=600, MAX_MISSES=3, sample_valid_i every cycle.
- Acquire: PSS N_id_2=1, then N_id=301 after 300 samples -> ssb_start_o 1 cycle after PSS, locked_o=1, N_id_o=301, state=LOCKED.
- Mismatch/timeout: PSS N_id_2=2, N_id=301 (mod 3 = 1) -> SEARCH, locked_o=0. Separately, no SSS for 600 samples -> SEARCH.
- Tracking: after lock, PSS N_id_2=1 at cnt=997 -> timing_err_o=-3 with valid strobe, ssb_start_o pulse, miss_cnt=0. A hit at cnt=1008 gives timing_err_o=+8.
- Window edges: PSS at cnt=991 (before the window) is ignored. PSS with N_id_2=0 inside the window is ignored. The window then closes at 1008 -> miss_cnt=1, blind ssb_start_o, cnt reloads to 8.
- Lock loss: 3 consecutive empty windows -> locked_o falls, state=SEARCH, pss_search_en_o=1, only 2 blind ssb_start_o pulses issued.
- Reset mid-TRACK: reset_ni low for 1 cycle -> all outputs return to reset values without waiting for a clock edge; the re-acquire sequence then succeeds.

Source files
------------

// File: rtl/ssb_sync_pkg.sv
// Shared types and constants for the SSB sync controller and its window timer.
package ssb_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        WAIT_SSS = 2'd1,
        LOCKED   = 2'd2,
        TRACK    = 2'd3
    } state_t;

    // Command to the window timer for the coming edge.
    typedef enum logic [1:0] {
        TMR_HOLD = 2'd0,
        TMR_CLR  = 2'd1,
        TMR_INC  = 2'd2,
        TMR_LOAD = 2'd3
    } tmr_op_t;

    localparam int N_ID_MAX = 1007;
    localparam int N_ID_W   = 10;

    // A cell id is consistent with a PSS sector when it is in range and N_id mod 3 == N_id_2.
    function automatic logic nid_consistent(input logic [N_ID_W-1:0] nid,
                                            input logic [1:0]        nid2);
        logic [N_ID_W-1:0] rem;
        rem = nid % N_ID_W'(3);
        return (nid <= N_ID_W'(N_ID_MAX)) && (rem == {{(N_ID_W-2){1'b0}}, nid2});
    endfunction

endpackage

// File: rtl/ssb_window_timer.sv
// Sample counter used for SSS timeout and the SSB flywheel, plus window compares
// and the timing-error subtract against the nominal SSB period.
module ssb_window_timer
    import ssb_sync_pkg::*;
#(
    parameter  int SSB_PERIOD  = 38400,
    parameter  int WINDOW_HALF = 64,
    parameter  int SSS_TIMEOUT = 2048,
    localparam int CNT_W       = $clog2(SSB_PERIOD + WINDOW_HALF + 1)
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  tmr_op_t            op_i,
    output logic               sss_timeout_o,  // cnt has reached the SSS timeout
    output logic               open_next_o,    // next increment lands on the window opening
    output logic               in_window_o,    // cnt has not passed the window close
    output logic               win_close_o,    // cnt sits on the window close
    output logic signed [CNT_W:0] timing_err_o // cnt - SSB_PERIOD
);

    localparam logic [CNT_W-1:0] OPEN_PRE = CNT_W'(SSB_PERIOD - WINDOW_HALF - 1);
    localparam logic [CNT_W-1:0] CLOSE    = CNT_W'(SSB_PERIOD + WINDOW_HALF);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(SSS_TIMEOUT);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(WINDOW_HALF);
    localparam logic [CNT_W:0]   PERIOD   = (CNT_W+1)'(SSB_PERIOD);

    logic [CNT_W-1:0] cnt_q;

    // Counter: cleared on (re)reference, reloaded to WINDOW_HALF on a flywheel miss.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            case (op_i)
                TMR_CLR:  cnt_q <= '0;
                TMR_INC:  cnt_q <= cnt_q + CNT_W'(1);
                TMR_LOAD: cnt_q <= HALF;
                default:  cnt_q <= cnt_q;
            endcase
        end
    end

    assign sss_timeout_o = (cnt_q >= TMO);
    assign open_next_o   = (cnt_q >= OPEN_PRE);
    assign in_window_o   = (cnt_q <= CLOSE);
    assign win_close_o   = (cnt_q >= CLOSE);
    assign timing_err_o  = $signed({1'b0, cnt_q} - PERIOD);

endmodule

// File: rtl/ssb_sync_controller.sv
// SSB acquisition/tracking sequencer: gates PSS search, starts FFT demod,
// validates the SSS cell id, then flywheels over the SSB period with a narrow
// PSS window and drops lock after repeated misses.
module ssb_sync_controller
    import ssb_sync_pkg::*;
#(
    parameter  int SSB_PERIOD  = 38400,
    parameter  int WINDOW_HALF = 64,
    parameter  int SSS_TIMEOUT = 2048,
    parameter  int MAX_MISSES  = 4,
    localparam int CNT_W       = $clog2(SSB_PERIOD + WINDOW_HALF + 1),
    localparam int MISS_W      = $clog2(MAX_MISSES + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 sample_valid_i,
    input  logic                 N_id_2_valid_i,
    input  logic [1:0]           N_id_2_i,
    input  logic                 N_id_valid_i,
    input  logic [N_ID_W-1:0]    N_id_i,
    output logic                 pss_search_en_o,
    output logic                 ssb_start_o,
    output logic [N_ID_W-1:0]    N_id_o,
    output logic                 locked_o,
    output logic [1:0]           state_o,
    output logic signed [CNT_W:0] timing_err_o,
    output logic                 timing_err_valid_o,
    output logic [MISS_W-1:0]    miss_cnt_o
);

    state_t                state_q;
    logic [1:0]            nid2_q;
    tmr_op_t               tmr_op;
    logic                  tmr_sss_to, tmr_open_next, tmr_in_win, tmr_close;
    logic signed [CNT_W:0] tmr_err;

    logic nid_ok, acq, sss_ok, sss_bad, sss_to, open_win, hit, miss, lose;

    ssb_window_timer #(
        .SSB_PERIOD  (SSB_PERIOD),
        .WINDOW_HALF (WINDOW_HALF),
        .SSS_TIMEOUT (SSS_TIMEOUT)
    ) u_timer (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .op_i         (tmr_op),
        .sss_timeout_o(tmr_sss_to),
        .open_next_o  (tmr_open_next),
        .in_window_o  (tmr_in_win),
        .win_close_o  (tmr_close),
        .timing_err_o (tmr_err)
    );

    // Event decode; all compares use the counter value before this cycle's increment.
    assign nid_ok   = nid_consistent(N_id_i, nid2_q);
    assign acq      = (state_q == SEARCH) && N_id_2_valid_i;
    assign sss_ok   = (state_q == WAIT_SSS) && N_id_valid_i && nid_ok;
    assign sss_bad  = (state_q == WAIT_SSS) && N_id_valid_i && !nid_ok;
    // A result arriving on the timeout cycle takes precedence.
    assign sss_to   = (state_q == WAIT_SSS) && !N_id_valid_i && tmr_sss_to;
    assign open_win = (state_q == LOCKED) && sample_valid_i && tmr_open_next;
    assign hit      = (state_q == TRACK) && N_id_2_valid_i && (N_id_2_i == nid2_q) && tmr_in_win;
    assign miss     = (state_q == TRACK) && !hit && tmr_close;
    assign lose     = miss && (miss_cnt_o == MISS_W'(MAX_MISSES - 1));

    assign state_o  = state_q;

    // Timer command: clear on a new reference or when idle, reload on a flywheel miss.
    always_comb begin
        tmr_op = TMR_HOLD;
        if (state_q == SEARCH || sss_bad || sss_to || hit || lose)
            tmr_op = TMR_CLR;
        else if (miss)
            tmr_op = TMR_LOAD;
        else if (sample_valid_i)
            tmr_op = TMR_INC;
    end

    // Sequencer with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q            <= SEARCH;
            pss_search_en_o    <= 1'b1;
            ssb_start_o        <= 1'b0;
            N_id_o             <= '0;
            locked_o           <= 1'b0;
            nid2_q             <= '0;
            timing_err_o       <= '0;
            timing_err_valid_o <= 1'b0;
            miss_cnt_o         <= '0;
        end else begin
            ssb_start_o        <= 1'b0;
            timing_err_valid_o <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (acq) begin
                        nid2_q          <= N_id_2_i;
                        ssb_start_o     <= 1'b1;
                        pss_search_en_o <= 1'b0;
                        state_q         <= WAIT_SSS;
                    end
                end
                WAIT_SSS: begin
                    if (sss_ok) begin
                        N_id_o     <= N_id_i;
                        locked_o   <= 1'b1;
                        miss_cnt_o <= '0;
                        state_q    <= LOCKED;
                    end else if (sss_bad || sss_to) begin
                        pss_search_en_o <= 1'b1;
                        state_q         <= SEARCH;
                    end
                end
                LOCKED: begin
                    if (open_win) begin
                        pss_search_en_o <= 1'b1;
                        state_q         <= TRACK;
                    end
                end
                TRACK: begin
                    if (hit) begin
                        timing_err_o       <= tmr_err;
                        timing_err_valid_o <= 1'b1;
                        ssb_start_o        <= 1'b1;
                        miss_cnt_o         <= '0;
                        pss_search_en_o    <= 1'b0;
                        state_q            <= LOCKED;
                    end else if (lose) begin
                        // Lock lost: no blind demod for this SSB.
                        locked_o        <= 1'b0;
                        miss_cnt_o      <= '0;
                        pss_search_en_o <= 1'b1;
                        state_q         <= SEARCH;
                    end else if (miss) begin
                        miss_cnt_o      <= miss_cnt_o + MISS_W'(1);
                        ssb_start_o     <= 1'b1;
                        pss_search_en_o <= 1'b0;
                        state_q         <= LOCKED;
                    end
                end
                default: begin
                    pss_search_en_o <= 1'b1;
                    state_q         <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssb_sync_controller.sv
// Randomized and directed bench for ssb_sync_controller against a behavioural model.
module tb_ssb_sync_controller;

    localparam int P  = 1000;
    localparam int W  = 8;
    localparam int TO = 600;
    localparam int MM = 3;
    localparam int CNT_W  = $clog2(P + W + 1);
    localparam int MISS_W = $clog2(MM + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic sv = 1'b0, pv = 1'b0, nv = 1'b0;
    logic [1:0] p2 = '0;
    logic [9:0] nid = '0;
    logic en, start, locked, tv;
    logic [9:0] nid_o;
    logic [1:0] st;
    logic signed [CNT_W:0] terr;
    logic [MISS_W-1:0] miss;

    ssb_sync_controller #(
        .SSB_PERIOD(P), .WINDOW_HALF(W), .SSS_TIMEOUT(TO), .MAX_MISSES(MM)
    ) dut (
        .clk_i(clk), .reset_ni(rst_n), .sample_valid_i(sv),
        .N_id_2_valid_i(pv), .N_id_2_i(p2), .N_id_valid_i(nv), .N_id_i(nid),
        .pss_search_en_o(en), .ssb_start_o(start), .N_id_o(nid_o), .locked_o(locked),
        .state_o(st), .timing_err_o(terr), .timing_err_valid_o(tv), .miss_cnt_o(miss)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;

    // Model: mode 0 search, 1 waiting SSS, 2 locked, 3 window open.
    // m_cnt = samples since the last SSB reference.
    int m_state = 0, m_cnt = 0, m_nid2 = 0, m_nid = 0, m_locked = 0, m_miss = 0;
    int e_start = 0, e_tv = 0, e_terr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_nid2 = 0; m_nid = 0; m_locked = 0; m_miss = 0;
        e_start = 0; e_tv = 0; e_terr = 0;
    endtask

    // Advance the model by one clock with the given inputs.
    task automatic model_step(input bit s, input bit p, input int p2v, input bit n, input int nidv);
        e_start = 0; e_tv = 0;
        case (m_state)
            0: begin
                m_cnt = 0;
                if (p) begin m_nid2 = p2v; e_start = 1; m_state = 1; end
            end
            1: begin
                if (n) begin
                    if (nidv <= 1007 && (nidv % 3) == m_nid2) begin
                        m_nid = nidv; m_locked = 1; m_miss = 0; m_state = 2;
                        if (s) m_cnt++;
                    end else begin
                        m_state = 0; m_cnt = 0;
                    end
                end else if (m_cnt >= TO) begin
                    m_state = 0; m_cnt = 0;
                end else if (s) m_cnt++;
            end
            2: begin
                if (s) begin m_cnt++; if (m_cnt == P - W) m_state = 3; end
            end
            default: begin
                if (p && p2v == m_nid2 && m_cnt <= P + W) begin
                    e_terr = m_cnt - P; e_tv = 1; e_start = 1;
                    m_cnt = 0; m_miss = 0; m_state = 2;
                end else if (m_cnt >= P + W) begin
                    m_miss++;
                    if (m_miss == MM) begin
                        m_locked = 0; m_miss = 0; m_state = 0; m_cnt = 0;
                    end else begin
                        m_cnt = W; e_start = 1; m_state = 2;
                    end
                end else if (s) m_cnt++;
            end
        endcase
    endtask

    task automatic compare();
        chk("state", int'(st), m_state);
        chk("search_en", int'(en), int'(m_state == 0 || m_state == 3));
        chk("locked", int'(locked), m_locked);
        chk("N_id_o", int'(nid_o), m_nid);
        chk("ssb_start", int'(start), e_start);
        chk("terr_valid", int'(tv), e_tv);
        if (e_tv != 0) chk("timing_err", int'(terr), e_terr);
        chk("miss_cnt", int'(miss), m_miss);
    endtask

    // Single compare process, sampling on the falling edge.
    bit cmp_en = 1'b1;
    always @(negedge clk) if (cmp_en) compare();

    // Drive one cycle of inputs after the falling edge; return just after the next rising edge.
    task automatic step(input bit s, input bit p, input int p2v, input bit n, input int nidv);
        @(negedge clk); #1;
        sv = s; pv = p; p2 = 2'(p2v); nv = n; nid = 10'(nidv);
        model_step(s, p, p2v, n, nidv);
        @(posedge clk); #2;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic wait_cnt(input int c);
        int g = 0;
        while (m_cnt != c && g < 3000) begin idle(); g++; end
        if (m_cnt != c) chk("wait_cnt_timeout", m_cnt, c);
    endtask

    task automatic async_reset();
        @(negedge clk); #1;
        sv = 0; pv = 0; nv = 0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_state", int'(st), 0);
        chk("arst_en", int'(en), 1);
        chk("arst_locked", int'(locked), 0);
        chk("arst_nid", int'(nid_o), 0);
        chk("arst_miss", int'(miss), 0);
        @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    int cnt_starts, wait_cycles, g;
    bit rs, rp, rn;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", int'(st), 0);
        chk("rst_en", int'(en), 1);
        chk("rst_locked", int'(locked), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_tv", int'(tv), 0);
        chk("rst_terr", int'(terr), 0);
        #1 rst_n = 1'b1;
        repeat (3) idle();

        // Acquire N_id 301 on sector 1
        step(1, 1, 1, 0, 0);
        chk("acq_start", int'(start), 1);
        chk("acq_state", int'(st), 1);
        wait_cnt(300);
        step(1, 0, 0, 1, 301);
        chk("lock_locked", int'(locked), 1);
        chk("lock_nid", int'(nid_o), 301);
        chk("lock_state", int'(st), 2);

        // Early and late-edge hits
        wait_cnt(997);
        step(1, 1, 1, 0, 0);
        chk("hit997_err", int'(terr), -3);
        chk("hit997_tv", int'(tv), 1);
        chk("hit997_start", int'(start), 1);
        chk("hit997_miss", int'(miss), 0);
        wait_cnt(1008);
        step(1, 1, 1, 0, 0);
        chk("hit1008_err", int'(terr), 8);
        chk("hit1008_tv", int'(tv), 1);

        // Peak before window, wrong sector inside window, then a miss
        wait_cnt(991);
        step(1, 1, 1, 0, 0);
        chk("pre_win_tv", int'(tv), 0);
        chk("pre_win_start", int'(start), 0);
        chk("win_open_state", int'(st), 3);
        wait_cnt(995);
        step(1, 1, 0, 0, 0);
        chk("wrong_sector_tv", int'(tv), 0);
        wait_cnt(1008);
        idle();
        chk("miss1_cnt", int'(miss), 1);
        chk("miss1_start", int'(start), 1);
        chk("miss1_state", int'(st), 2);

        // Re-centre with a hit on time, then three empty windows
        wait_cnt(1000);
        step(1, 1, 1, 0, 0);
        chk("hit1000_err", int'(terr), 0);
        chk("hit1000_miss", int'(miss), 0);
        cnt_starts = 0; g = 0;
        while (m_state != 0 && g < 5000) begin
            idle(); g++;
            if (start) cnt_starts++;
        end
        chk("loss_blind_starts", cnt_starts, 2);
        chk("loss_locked", int'(locked), 0);
        chk("loss_state", int'(st), 0);
        chk("loss_en", int'(en), 1);
        chk("loss_nid_hold", int'(nid_o), 301);

        // Sector mismatch
        step(1, 1, 2, 0, 0);
        wait_cnt(300);
        step(1, 0, 0, 1, 301);
        chk("mismatch_state", int'(st), 0);
        chk("mismatch_locked", int'(locked), 0);

        // SSS timeout
        step(1, 1, 0, 0, 0);
        wait_cycles = (st == 2'd1) ? 1 : 0;
        g = 0;
        while (m_state != 0 && g < 2000) begin
            idle(); g++;
            if (st == 2'd1) wait_cycles++;
        end
        chk("timeout_wait_cycles", wait_cycles, 601);
        chk("timeout_state", int'(st), 0);

        // Lock on sector 0, reset inside the window
        step(1, 1, 0, 0, 0);
        wait_cnt(50);
        step(1, 0, 0, 1, 600);
        chk("lock600_nid", int'(nid_o), 600);
        wait_cnt(995);
        chk("pre_reset_state", int'(st), 3);
        async_reset();

        // Out-of-range id rejected; id 1007 on the timeout cycle accepted
        step(1, 1, 2, 0, 0);
        wait_cnt(10);
        step(1, 0, 0, 1, 1010);
        chk("nid1010_state", int'(st), 0);
        step(1, 1, 2, 0, 0);
        wait_cnt(600);
        step(1, 0, 0, 1, 1007);
        chk("nid1007_locked", int'(locked), 1);
        chk("nid1007_nid", int'(nid_o), 1007);

        // Random traffic, sparse sample strobe
        for (int i = 0; i < 6000; i++) begin
            rs = ($urandom_range(0, 3) != 0);
            rp = (m_state == 3) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 99) == 0);
            step(rs, rp, int'($urandom_range(0, 2)), rn, int'($urandom_range(0, 1023)));
        end

        @(negedge clk); #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
